// File: rtl/spi_pkg.sv
// Shared definitions for the SPI mode-1 slave control unit: state encoding,
// field length default, MISO mux select values and the debug view struct.
package spi_pkg;

    localparam int BITS_PER_REG_DEF = 8;

    localparam logic MUX_REG1 = 1'b0;
    localparam logic MUX_REG2 = 1'b1;

    typedef logic [2:0] state_t;

    localparam state_t ST_INIT   = 3'd0;
    localparam state_t ST_IDLE   = 3'd1;
    localparam state_t ST_FIELD1 = 3'd2;
    localparam state_t ST_FIELD2 = 3'd3;
    localparam state_t ST_LOAD   = 3'd4;
    localparam state_t ST_HOLD   = 3'd5;

    typedef struct packed {
        state_t state;
        logic   sck_s;
        logic   sck_rise;
        logic   cs_s;
        logic   cs_rise;
        logic   cs_fall;
    } spi_dbg_t;

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchroniser for an asynchronous input plus a history flop that
// turns the synchronised level into single-cycle rise/fall indications.
module spi_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = ~hist_q & sync_q[SYNC_STAGES-1];
    assign fall  = hist_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave_cu.sv
// Control unit for the SPI mode-1 slave datapath: frames each chip-select
// window into two 8-bit fields and drives shift, mux, load and reset strobes.
module spi_slave_cu
    import spi_pkg::*;
#(
    parameter int BITS_PER_REG = BITS_PER_REG_DEF,
    parameter int SYNC_STAGES  = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     sck,
    input  logic     chipSelect,
    output logic     cu_2_dp_rst,
    output logic     shftEnable_1,
    output logic     shftEnable_2,
    output logic     mux_select,
    output logic     red_led_enb,
    output logic     blue_led_enb,
    output logic     frame_done,
    output logic     frame_err,
    output spi_dbg_t dbg
);

    localparam int CNT_W = $clog2(BITS_PER_REG);

    logic             sck_s;
    logic             sck_rise;
    logic             sck_fall;
    logic             cs_s;
    logic             cs_rise;
    logic             cs_fall;
    state_t           state;
    logic [CNT_W-1:0] bit_cnt;
    logic             last_bit;

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (sck),
        .level (sck_s),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (chipSelect),
        .level (cs_s),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    assign last_bit = (bit_cnt == CNT_W'(BITS_PER_REG - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_INIT;
            bit_cnt      <= '0;
            cu_2_dp_rst  <= 1'b1;
            shftEnable_1 <= 1'b0;
            shftEnable_2 <= 1'b0;
            mux_select   <= MUX_REG1;
            red_led_enb  <= 1'b0;
            blue_led_enb <= 1'b0;
            frame_done   <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            cu_2_dp_rst  <= 1'b0;
            shftEnable_1 <= 1'b0;
            shftEnable_2 <= 1'b0;
            red_led_enb  <= 1'b0;
            blue_led_enb <= 1'b0;
            frame_done   <= 1'b0;
            frame_err    <= 1'b0;
            case (state)
                ST_INIT: begin
                    cu_2_dp_rst <= 1'b1;
                    state       <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (cs_s) begin
                        bit_cnt    <= '0;
                        mux_select <= MUX_REG1;
                        state      <= ST_FIELD1;
                    end
                end
                ST_FIELD1, ST_FIELD2: begin
                    // Deselect takes priority over a coincident SCK fall.
                    if (!cs_s) begin
                        frame_err   <= 1'b1;
                        cu_2_dp_rst <= 1'b1;
                        bit_cnt     <= '0;
                        mux_select  <= MUX_REG1;
                        state       <= ST_IDLE;
                    end else if (sck_fall) begin
                        if (state == ST_FIELD1) begin
                            shftEnable_1 <= 1'b1;
                        end else begin
                            shftEnable_2 <= 1'b1;
                        end
                        if (last_bit) begin
                            bit_cnt <= '0;
                            if (state == ST_FIELD1) begin
                                mux_select <= MUX_REG2;
                                state      <= ST_FIELD2;
                            end else begin
                                state <= ST_LOAD;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_LOAD: begin
                    red_led_enb  <= 1'b1;
                    blue_led_enb <= 1'b1;
                    frame_done   <= 1'b1;
                    state        <= ST_HOLD;
                end
                ST_HOLD: begin
                    // Surplus SCK edges are ignored until the master deselects.
                    if (!cs_s) begin
                        mux_select <= MUX_REG1;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    always_comb begin
        dbg          = '0;
        dbg.state    = state;
        dbg.sck_s    = sck_s;
        dbg.sck_rise = sck_rise;
        dbg.cs_s     = cs_s;
        dbg.cs_rise  = cs_rise;
        dbg.cs_fall  = cs_fall;
    end

endmodule

// File: tb/tb_spi_slave_cu.sv
// Bench for spi_slave_cu: frame-level model schedules expected strobes from
// pin events; every cycle the DUT output vector is compared against it.
module tb_spi_slave_cu;
    import spi_pkg::*;

    localparam int SZ     = 4096;
    localparam int LAT    = 3;
    localparam int B_RST  = 7;
    localparam int B_S1   = 6;
    localparam int B_S2   = 5;
    localparam int B_MUX  = 4;
    localparam int B_RED  = 3;
    localparam int B_BLUE = 2;
    localparam int B_DONE = 1;
    localparam int B_ERR  = 0;

    logic     clk = 1'b0;
    logic     rst_n;
    logic     sck;
    logic     chipSelect;
    logic     cu_2_dp_rst;
    logic     shftEnable_1;
    logic     shftEnable_2;
    logic     mux_select;
    logic     red_led_enb;
    logic     blue_led_enb;
    logic     frame_done;
    logic     frame_err;
    spi_dbg_t dbg;

    spi_slave_cu dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sck          (sck),
        .chipSelect   (chipSelect),
        .cu_2_dp_rst  (cu_2_dp_rst),
        .shftEnable_1 (shftEnable_1),
        .shftEnable_2 (shftEnable_2),
        .mux_select   (mux_select),
        .red_led_enb  (red_led_enb),
        .blue_led_enb (blue_led_enb),
        .frame_done   (frame_done),
        .frame_err    (frame_err),
        .dbg          (dbg)
    );

    // clock / cycle index
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // model: expected pulse vectors and mux level changes indexed by cycle
    logic [7:0] exp_vec[SZ];
    logic [1:0] mux_chg[SZ];
    logic       m_active;
    int         m_n;
    logic       cur_mux;

    int errors = 0;
    int checks = 0;
    int cnt_s1 = 0, cnt_s2 = 0, cnt_red = 0, cnt_blue = 0, cnt_done = 0, cnt_err = 0;
    int last_s1_cyc = 0;
    int last_fall_cyc = 0;

    function automatic void sched(int idx, int b);
        if (idx < SZ) exp_vec[idx][b] = 1'b1;
    endfunction

    function automatic void sched_mux(int idx, logic v);
        if (idx < SZ) mux_chg[idx] = v ? 2'd2 : 2'd1;
    endfunction

    // A pin event after edge k is reflected in the outputs after edge k+LAT.
    function automatic void ev_fall();
        if (m_active && m_n < 2 * BITS_PER_REG_DEF) begin
            sched(cyc + LAT, (m_n < BITS_PER_REG_DEF) ? B_S1 : B_S2);
            m_n = m_n + 1;
            if (m_n == BITS_PER_REG_DEF) sched_mux(cyc + LAT, 1'b1);
            if (m_n == 2 * BITS_PER_REG_DEF) begin
                sched(cyc + LAT + 1, B_RED);
                sched(cyc + LAT + 1, B_BLUE);
                sched(cyc + LAT + 1, B_DONE);
            end
        end
    endfunction

    function automatic void ev_cs(logic v);
        if (v) begin
            m_active = 1'b1;
            m_n      = 0;
        end else begin
            if (m_active) begin
                if (m_n < 2 * BITS_PER_REG_DEF) begin
                    sched(cyc + LAT, B_ERR);
                    sched(cyc + LAT, B_RST);
                end
                sched_mux(cyc + LAT, 1'b0);
            end
            m_active = 1'b0;
        end
    endfunction

    function automatic void ev_rst_assert();
        for (int j = cyc; j < SZ; j++) begin
            exp_vec[j] = '0;
            mux_chg[j] = '0;
        end
        m_active = 1'b0;
        m_n      = 0;
    endfunction

    function automatic void ev_rst_release();
        sched(cyc, B_RST);
        sched(cyc + 1, B_RST);
    endfunction

    function automatic logic [7:0] dut_vec();
        return {cu_2_dp_rst, shftEnable_1, shftEnable_2, mux_select,
                red_led_enb, blue_led_enb, frame_done, frame_err};
    endfunction

    // scoreboard compare, called once per cycle at the falling clk edge
    task automatic sample_compare();
        logic [7:0] got;
        logic [7:0] exp;
        got = dut_vec();
        if (!rst_n) begin
            exp     = 8'h80;
            cur_mux = 1'b0;
        end else begin
            if (mux_chg[cyc] != 2'd0) cur_mux = (mux_chg[cyc] == 2'd2);
            exp        = exp_vec[cyc];
            exp[B_MUX] = cur_mux;
        end
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL cycle_cmp cyc=%0d got=%b exp=%b", cyc, got, exp);
        end
        if (rst_n) begin
            cnt_s1   += int'(shftEnable_1);
            cnt_s2   += int'(shftEnable_2);
            cnt_red  += int'(red_led_enb);
            cnt_blue += int'(blue_led_enb);
            cnt_done += int'(frame_done);
            cnt_err  += int'(frame_err);
            if (shftEnable_1) last_s1_cyc = cyc;
        end
    endtask

    task automatic lit(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // driver tasks: each starts and ends 2 time units after a rising clk edge
    task automatic step();
        @(negedge clk);
        sample_compare();
        @(posedge clk);
        #2;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic set_cs(input logic v);
        chipSelect = v;
        ev_cs(v);
    endtask

    task automatic sck_period();
        sck = 1'b1;
        steps(5);
        sck           = 1'b0;
        last_fall_cyc = cyc;
        ev_fall();
        steps(5);
    endtask

    task automatic frame(input string name, input int n_sck);
        int b_s1, b_s2, b_red, b_blue, b_done, b_err;
        b_s1 = cnt_s1; b_s2 = cnt_s2; b_red = cnt_red;
        b_blue = cnt_blue; b_done = cnt_done; b_err = cnt_err;
        set_cs(1'b1);
        steps(4);
        sck_period();
        lit({name, "_latency"}, last_s1_cyc - last_fall_cyc, 3);
        repeat (n_sck - 1) sck_period();
        steps(4);
        set_cs(1'b0);
        steps(8);
        lit({name, "_s1"}, cnt_s1 - b_s1, 8);
        lit({name, "_s2"}, cnt_s2 - b_s2, 8);
        lit({name, "_red"}, cnt_red - b_red, 1);
        lit({name, "_blue"}, cnt_blue - b_blue, 1);
        lit({name, "_done"}, cnt_done - b_done, 1);
        lit({name, "_err"}, cnt_err - b_err, 0);
        lit({name, "_mux"}, int'(mux_select), 0);
        lit({name, "_state"}, int'(dbg.state), int'(ST_IDLE));
    endtask

    initial begin
        int b_s1, b_s2, b_red, b_done, b_err;
        for (int j = 0; j < SZ; j++) begin
            exp_vec[j] = '0;
            mux_chg[j] = '0;
        end
        m_active   = 1'b0;
        m_n        = 0;
        cur_mux    = 1'b0;
        rst_n      = 1'b0;
        sck        = 1'b0;
        chipSelect = 1'b0;

        // reset and idle
        steps(5);
        lit("reset_dp_rst", int'(cu_2_dp_rst), 1);
        lit("reset_vec", int'(dut_vec()), 8'h80);
        rst_n = 1'b1;
        ev_rst_release();
        steps(20);
        lit("idle_state", int'(dbg.state), int'(ST_IDLE));
        lit("idle_no_pulses", cnt_s1 + cnt_s2 + cnt_done + cnt_err, 0);

        // full frame
        frame("full", 16);

        // early deselect after 5 falls, then a normal frame
        b_s1 = cnt_s1; b_red = cnt_red; b_done = cnt_done; b_err = cnt_err;
        set_cs(1'b1);
        steps(4);
        repeat (5) sck_period();
        set_cs(1'b0);
        steps(8);
        lit("abort_s1", cnt_s1 - b_s1, 5);
        lit("abort_err", cnt_err - b_err, 1);
        lit("abort_red", cnt_red - b_red, 0);
        lit("abort_done", cnt_done - b_done, 0);
        lit("abort_state", int'(dbg.state), int'(ST_IDLE));
        frame("after_abort", 16);

        // surplus SCK cycles inside one window
        frame("overclock", 20);

        // 12th fall and deselect land in the same synchronised cycle
        b_s2 = cnt_s2; b_done = cnt_done; b_err = cnt_err;
        set_cs(1'b1);
        steps(4);
        repeat (11) sck_period();
        sck = 1'b1;
        steps(5);
        sck        = 1'b0;
        chipSelect = 1'b0;
        ev_cs(1'b0);
        ev_fall();
        steps(8);
        lit("simul_s2", cnt_s2 - b_s2, 3);
        lit("simul_err", cnt_err - b_err, 1);
        lit("simul_done", cnt_done - b_done, 0);

        // reset asserted during field 2
        set_cs(1'b1);
        steps(4);
        repeat (10) sck_period();
        rst_n = 1'b0;
        ev_rst_assert();
        #1;
        lit("midrst_vec", int'(dut_vec()), 8'h80);
        chipSelect = 1'b0;
        steps(3);
        rst_n = 1'b1;
        ev_rst_release();
        steps(5);
        frame("after_rst", 16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_slave_cu.md
Name: spi_slave_cu

Overview:
Control unit for the SPI mode-1 (CPOL=0, CPHA=1) slave datapath. It oversamples raw SCK with the system clock and frames each chip-select transaction as two back-to-back 8-bit fields. It generates the shift enables, MISO mux select, LED-register load strobes and datapath reset that the datapath consumes. One frame is 16 SCK cycles: field 1 (RED) goes into shift register 1, then field 2 (BLUE) goes into shift register 2.

Parameters:
BITS_PER_REG, 8, SCK falling edges per field; bit counter width is clog2(BITS_PER_REG).
SYNC_STAGES, 2, synchroniser depth for sck and chipSelect; legal values are 2 or 3.

Ports:
clk  input  1  system clock; must be at least 8x the SCK frequency.
rst_n  input  1  asynchronous active-low reset.
sck  input  1  raw SPI clock; idles low.
chipSelect  input  1  raw slave select, active-high; the same polarity the datapath uses.
cu_2_dp_rst  output  1  datapath reset, active-high.
shftEnable_1  output  1  one-cycle shift pulse for register 1.
shftEnable_2  output  1  one-cycle shift pulse for register 2.
mux_select  output  1  MISO source select; 0 = register 1 LSB, 1 = register 2 LSB.
red_led_enb  output  1  one-cycle load strobe for RED_LED_REG.
blue_led_enb  output  1  one-cycle load strobe for BLUE_LED_REG.
frame_done  output  1  one-cycle pulse when a complete 16-bit frame is accepted.
frame_err  output  1  one-cycle pulse when a frame aborts because chipSelect dropped early.

Behaviour:
- Reset:
  - While rst_n is low, all outputs are 0 except cu_2_dp_rst, which is 1.
  - The state is INIT, bit_cnt is 0, and the synchroniser flops are 0.
- Synchronisation:
  - sck and chipSelect pass through SYNC_STAGES flops, plus one history flop on sck.
  - fall = history & ~sync; rise = ~history & sync; cs_s is the synchronised chipSelect.
- Latency: from a falling SCK edge at the pin to the shftEnable pulse is SYNC_STAGES+1 clk cycles.
- All outputs are registered. Every pulse output is high for exactly one clk cycle.
- States:
  - INIT: cu_2_dp_rst=1 for one cycle, then go to IDLE.
  - IDLE: wait for cs_s=1. On cs_s=1, clear bit_cnt, set mux_select=0, and go to FIELD1.
  - FIELD1: on each fall, pulse shftEnable_1 and increment bit_cnt. On the fall that brings bit_cnt to BITS_PER_REG, do all of the following in the same cycle:
    - pulse shftEnable_1;
    - clear bit_cnt;
    - set mux_select=1, effective from the next cycle, so register 2 drives MISO before the next SCK rise;
    - go to FIELD2.
  - FIELD2: same as FIELD1 using shftEnable_2. On the last bit, go to LOAD.
  - LOAD: pulse red_led_enb, blue_led_enb and frame_done together for one cycle, then go to HOLD.
  - HOLD: ignore all further SCK edges while cs_s=1; shift enables stay 0. On cs_s=0, set mux_select=0 and go to IDLE.
- Abort:
  - Trigger: cs_s goes 0 while in FIELD1 or FIELD2.
  - In the next cycle, pulse frame_err and cu_2_dp_rst together and clear bit_cnt.
  - No led_enb pulse is issued, so the LED registers keep their previous values.
  - Go to IDLE.
- Simultaneous fall and cs_s deassert in the same cycle: the abort wins and no shift pulse is issued.
- sck rise is used only for the edge-history update. MISO timing is the datapath's concern; the controller guarantees only that mux_select is stable across every rise inside a field.
- bit_cnt never exceeds BITS_PER_REG-1 when observed; no wrap-around occurs because it is cleared on field change.
- An asynchronous rst_n assertion mid-frame forces INIT behaviour immediately, with no strobes.

Decomposition:
- Shared package spi_pkg holds:
  - the state enum (INIT, IDLE, FIELD1, FIELD2, LOAD, HOLD);
  - the BITS_PER_REG default;
  - the MUX_REG1=0 and MUX_REG2=1 constants.
- One sub-module, spi_edge_sync, contains the SYNC_STAGES synchroniser and the rise/fall detector. It is instantiated once for sck (edge outputs used) and once for chipSelect (level output used).

Test Plan:
- Reset and idle: hold rst_n=0 for 5 clk, then release. Require cu_2_dp_rst=1 during reset and for 1 cycle after, then 0; all other outputs stay 0 for 20 cycles with chipSelect=0.
- Full frame: chipSelect=1 with 16 SCK periods at clk/10.
  - Require 8 shftEnable_1 pulses followed by 8 shftEnable_2 pulses.
  - Each pulse occurs 3 clk after its SCK fall.
  - mux_select goes 0→1 after pulse 8.
  - One cycle of red_led_enb, blue_led_enb and frame_done together.
- Early deselect: drop chipSelect after 5 SCK falls. Require frame_err and cu_2_dp_rst to pulse once, no led_enb pulse, the state returns to IDLE, and the next full frame completes normally.
- Overclocking in HOLD: apply 20 SCK cycles within one chipSelect window. Require exactly 16 shift pulses, one frame_done, no frame_err, and mux_select=0 after chipSelect falls.
- Simultaneous events: drive the 12th SCK fall and chipSelect deassert in the same synchronised cycle. Require no 12th shftEnable_2 pulse and frame_err=1.
- Mid-frame reset: assert rst_n=0 during field 2. Require all strobes 0 immediately, cu_2_dp_rst=1, and a clean frame after release.
